// File: rtl/uart_tx_frame_pkg.sv
// Shared types and encodings for the UART TX frame engine.
package uart_tx_pkg;

  // Framing FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } tx_state_e;

  // Output line select encoding (3 bits leaves room for future sources).
  localparam logic [2:0] SEL_IDLE  = 3'd0;
  localparam logic [2:0] SEL_START = 3'd1;
  localparam logic [2:0] SEL_DATA  = 3'd2;
  localparam logic [2:0] SEL_PAR   = 3'd3;
  localparam logic [2:0] SEL_BRK   = 3'd4;

  // Parity type encoding of PAR_TYP.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake and serial line bundle of the UART TX frame engine.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic                  BREAK;
  logic                  TX_OUT;
  logic                  BUSY;

  // Producer side: register interface feeding the engine.
  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, BREAK,
    input  TX_OUT, BUSY
  );

  // Engine side.
  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, BREAK,
    output TX_OUT, BUSY
  );
endinterface

// File: rtl/uart_tx_frame_line_sel.sv
// Registered TX line driver: selects idle/start/data/parity/break level and
// flops it so the pin never glitches. Unknown selects fall back to idle (1).
module uart_tx_line_sel
  import uart_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel,
  input  logic       data_bit,
  input  logic       par_bit,
  output logic       tx_out
);

  logic line_d;

  // Line level for the bit being entered on the next edge.
  always_comb begin
    line_d = 1'b1;
    case (sel)
      SEL_IDLE:  line_d = 1'b1;
      SEL_START: line_d = 1'b0;
      SEL_DATA:  line_d = data_bit;
      SEL_PAR:   line_d = par_bit;
      SEL_BRK:   line_d = 1'b0;
      default:   line_d = 1'b1;
    endcase
  end

  // Registered line; idle-high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_out <= 1'b1;
    else     tx_out <= line_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART TX frame engine: latches a word on the valid/busy handshake and
// serialises start, data (LSB first), optional parity and 1 or 2 stop bits.
// One CLK cycle is one bit time. BREAK holds the line low from IDLE.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_frame_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;
  localparam logic [2:0] S_BRK    = BRK;

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_frame: DATA_WIDTH must be within 5..9");
  end

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q, par_typ_q, stop2_q;
  logic                  stop_2nd_q, stop_2nd_d;
  logic                  busy_q;
  logic                  load;
  logic [2:0]            sel;
  logic                  data_bit;
  logic                  par_bit;

  // Parity over the latched word; odd type inverts the even result.
  assign par_bit = (^data_q) ^ par_typ_q;

  // Next state, counter and line select for the state being entered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stop_2nd_d = stop_2nd_q;
    sel        = SEL_IDLE;
    data_bit   = 1'b1;
    load       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // BREAK wins over a simultaneous request.
        if (bus.BREAK) begin
          state_d = S_BRK;
          sel     = SEL_BRK;
        end else if (bus.DATA_VALID) begin
          state_d = S_START;
          sel     = SEL_START;
          load    = 1'b1;
        end
      end
      S_START: begin
        state_d  = S_DATA;
        cnt_d    = '0;
        sel      = SEL_DATA;
        data_bit = data_q[0];
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          // Counter holds at the last index; it never wraps.
          if (par_en_q) begin
            state_d = S_PARITY;
            sel     = SEL_PAR;
          end else begin
            state_d    = S_STOP;
            stop_2nd_d = 1'b0;
          end
        end else begin
          cnt_d    = cnt_q + 1'b1;
          sel      = SEL_DATA;
          data_bit = data_q[cnt_d];
        end
      end
      S_PARITY: begin
        state_d    = S_STOP;
        stop_2nd_d = 1'b0;
      end
      S_STOP: begin
        if (stop2_q && !stop_2nd_q) stop_2nd_d = 1'b1;
        else                        state_d    = S_IDLE;
      end
      S_BRK: begin
        if (bus.BREAK) sel     = SEL_BRK;
        else           state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, bit counter and busy flag; reset aborts any frame in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      stop_2nd_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stop_2nd_q <= stop_2nd_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  // Word and frame configuration captured on the accepting edge only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      stop2_q   <= 1'b0;
    end else if (load) begin
      data_q    <= bus.P_DATA;
      par_en_q  <= bus.PAR_EN;
      par_typ_q <= bus.PAR_TYP;
      stop2_q   <= bus.STOP2;
    end
  end

  assign bus.BUSY = busy_q;

  uart_tx_line_sel u_line_sel (
    .clk      (CLK),
    .rst      (RST),
    .sel      (sel),
    .data_bit (data_bit),
    .par_bit  (par_bit),
    .tx_out   (bus.TX_OUT)
  );

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frames, handshake corners,
// BREAK, async reset, random frames, plus 5- and 9-bit builds.
module tb_uart_tx_frame;
  import uart_tx_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] exp_bits;
  int          exp_len;

  always #5 CLK = ~CLK;

  uart_tx_frame_if #(.DATA_WIDTH(8)) b8 ();
  uart_tx_frame_if #(.DATA_WIDTH(5)) b5 ();
  uart_tx_frame_if #(.DATA_WIDTH(9)) b9 ();

  uart_tx_frame #(.DATA_WIDTH(8)) dut8 (.CLK(CLK), .RST(RST), .bus(b8));
  uart_tx_frame #(.DATA_WIDTH(5)) dut5 (.CLK(CLK), .RST(RST), .bus(b5));
  uart_tx_frame #(.DATA_WIDTH(9)) dut9 (.CLK(CLK), .RST(RST), .bus(b9));

  // Reference frame as a bit string, element 0 first on the line; positions
  // past the frame are 1 (stop bits and idle line).
  function automatic logic [15:0] model_bits(int w, logic [8:0] d, logic pen, logic ptyp);
    logic [15:0] v;
    int n;
    int ones;
    v = '1;
    ones = 0;
    v[0] = 1'b0;
    n = 1;
    for (int i = 0; i < w; i++) begin
      v[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (pen) v[n] = (ptyp == PAR_ODD) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return v;
  endfunction

  function automatic int model_len(int w, logic pen, logic s2);
    return 1 + w + int'(pen) + 1 + int'(s2);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called just after the start-bit edge; walks the frame and the idle cycle.
  task automatic check_frame(input string tag);
    for (int i = 0; i < exp_len; i++) begin
      chk($sformatf("%s_tx%0d", tag, i), b8.TX_OUT, exp_bits[i]);
      chk($sformatf("%s_busy%0d", tag, i), b8.BUSY, 1'b1);
      @(posedge CLK); #1;
    end
    chk({tag, "_end_tx"}, b8.TX_OUT, 1'b1);
    chk({tag, "_end_busy"}, b8.BUSY, 1'b0);
  endtask

  // One-cycle request from IDLE; config inputs are scrambled after acceptance.
  task automatic request8(input logic [7:0] d, input logic pen, input logic ptyp,
                          input logic s2, input string tag);
    b8.P_DATA     = d;
    b8.PAR_EN     = pen;
    b8.PAR_TYP    = ptyp;
    b8.STOP2      = s2;
    b8.DATA_VALID = 1'b1;
    exp_bits = model_bits(8, {1'b0, d}, pen, ptyp);
    exp_len  = model_len(8, pen, s2);
    @(posedge CLK); #1;
    b8.DATA_VALID = 1'b0;
    b8.P_DATA     = 8'($urandom);
    b8.PAR_EN     = 1'($urandom);
    b8.PAR_TYP    = 1'($urandom);
    b8.STOP2      = 1'($urandom);
    check_frame(tag);
  endtask

  initial begin
    logic [15:0] v5, v9;
    int l5, l9;

    RST = 1'b1;
    b8.P_DATA = '0; b8.DATA_VALID = 1'b0; b8.PAR_EN = 1'b0; b8.PAR_TYP = 1'b0; b8.STOP2 = 1'b0; b8.BREAK = 1'b0;
    b5.P_DATA = '0; b5.DATA_VALID = 1'b0; b5.PAR_EN = 1'b0; b5.PAR_TYP = 1'b0; b5.STOP2 = 1'b0; b5.BREAK = 1'b0;
    b9.P_DATA = '0; b9.DATA_VALID = 1'b0; b9.PAR_EN = 1'b0; b9.PAR_TYP = 1'b0; b9.STOP2 = 1'b0; b9.BREAK = 1'b0;
    #12;
    chk("rst_tx8", b8.TX_OUT, 1'b1);
    chk("rst_busy8", b8.BUSY, 1'b0);
    chk("rst_tx5", b5.TX_OUT, 1'b1);
    chk("rst_busy9", b9.BUSY, 1'b0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    chk("idle_tx", b8.TX_OUT, 1'b1);
    chk("idle_busy", b8.BUSY, 1'b0);

    // Basic frames, parity types and two stop bits.
    request8(8'hA5, 1'b0, 1'b0, 1'b0, "a5");
    request8(8'h07, 1'b1, PAR_EVEN, 1'b0, "p_even");
    request8(8'h07, 1'b1, PAR_ODD, 1'b0, "p_odd");
    request8(8'h07, 1'b1, PAR_EVEN, 1'b1, "stop2");

    // DATA_VALID held: second word launches after one idle cycle; mid-frame
    // input changes must not leak into the first frame.
    b8.P_DATA = 8'h01; b8.PAR_EN = 1'b0; b8.PAR_TYP = 1'b0; b8.STOP2 = 1'b0;
    b8.DATA_VALID = 1'b1;
    exp_bits = model_bits(8, 9'h001, 1'b0, 1'b0);
    exp_len  = model_len(8, 1'b0, 1'b0);
    @(posedge CLK); #1;
    b8.P_DATA = 8'h80; b8.PAR_TYP = 1'b1;
    check_frame("b2b_1");
    @(posedge CLK); #1;
    b8.DATA_VALID = 1'b0;
    exp_bits = model_bits(8, 9'h080, 1'b0, 1'b1);
    check_frame("b2b_2");

    // BREAK with a simultaneous request: BREAK first, then the frame.
    b8.P_DATA = 8'h3C; b8.BREAK = 1'b1; b8.DATA_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("brk_tx%0d", i), b8.TX_OUT, 1'b0);
      chk($sformatf("brk_busy%0d", i), b8.BUSY, 1'b1);
    end
    b8.BREAK = 1'b0;
    @(posedge CLK); #1;
    chk("brk_exit_tx", b8.TX_OUT, 1'b1);
    chk("brk_exit_busy", b8.BUSY, 1'b0);
    @(posedge CLK); #1;
    b8.DATA_VALID = 1'b0;
    exp_bits = model_bits(8, 9'h03C, 1'b0, 1'b0);
    exp_len  = model_len(8, 1'b0, 1'b0);
    check_frame("brk_frame");

    // Async reset during data bit 3 of 0x00.
    b8.P_DATA = 8'h00; b8.PAR_EN = 1'b0; b8.STOP2 = 1'b0; b8.DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    b8.DATA_VALID = 1'b0;
    repeat (4) begin @(posedge CLK); #1; end
    chk("pre_rst_busy", b8.BUSY, 1'b1);
    chk("pre_rst_tx", b8.TX_OUT, 1'b0);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_tx", b8.TX_OUT, 1'b1);
    chk("async_rst_busy", b8.BUSY, 1'b0);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("post_rst_tx", b8.TX_OUT, 1'b1);
    chk("post_rst_busy", b8.BUSY, 1'b0);
    request8(8'h5A, 1'b1, PAR_ODD, 1'b0, "post_rst");

    // Random frames against the model.
    for (int k = 0; k < 20; k++) begin
      request8(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", k));
    end

    // 5- and 9-bit builds, all-ones word, even parity, one stop bit.
    b5.P_DATA = '1; b5.PAR_EN = 1'b1; b5.PAR_TYP = PAR_EVEN; b5.STOP2 = 1'b0; b5.DATA_VALID = 1'b1;
    b9.P_DATA = '1; b9.PAR_EN = 1'b1; b9.PAR_TYP = PAR_EVEN; b9.STOP2 = 1'b0; b9.DATA_VALID = 1'b1;
    v5 = model_bits(5, 9'h01F, 1'b1, 1'b0); l5 = model_len(5, 1'b1, 1'b0);
    v9 = model_bits(9, 9'h1FF, 1'b1, 1'b0); l9 = model_len(9, 1'b1, 1'b0);
    @(posedge CLK); #1;
    b5.DATA_VALID = 1'b0; b9.DATA_VALID = 1'b0;
    for (int c = 0; c < 14; c++) begin
      chk($sformatf("w5_tx%0d", c), b5.TX_OUT, v5[c]);
      chk($sformatf("w5_busy%0d", c), b5.BUSY, c < l5);
      chk($sformatf("w9_tx%0d", c), b9.TX_OUT, v9[c]);
      chk($sformatf("w9_busy%0d", c), b9.BUSY, c < l9);
      @(posedge CLK); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
